decode_stage_m: RTL and testbench

//  Registered LEGv8 instruction-decode stage between fetch and register-read/execute.

---
 rtl/decode_stage_m.sv | 164 ++++++++++++++++
 tb/tb_decode_stage_m.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_m.sv
// rtl/decode_stage_m.sv - registered LEGv8 decode stage with valid/ready output register
// Load-use interlock and stall counter are present only when LOAD_USE_INTERLOCK_EN is defined.
module decode_stage_m #(
  parameter int DATA_W = 64,
  parameter int PC_W   = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [10:0]       out_opcode,
  output logic [4:0]        out_rn,
  output logic [4:0]        out_rm,
  output logic [4:0]        out_rd,
  output logic [DATA_W-1:0] out_imm,
  output logic              out_uncond,
  output logic              out_branch,
  output logic              out_br_nz,
  output logic              out_memread,
  output logic              out_memwrite,
  output logic              out_memtoreg,
  output logic              out_alusrc,
  output logic              out_regwrite,
  output logic [1:0]        out_aluop,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  stall_cnt
);
  logic [10:0]       w_op11;
  logic [9:0]        w_op10;
  logic              w_is_r, w_is_i;
  logic [4:0]        w_rn, w_rm, w_rd;
  logic [DATA_W-1:0] w_imm;
  logic              w_uncond, w_branch, w_br_nz, w_memread, w_memwrite;
  logic              w_memtoreg, w_alusrc, w_regwrite, w_illegal;
  logic [1:0]        w_aluop;
  logic              w_use_rn, w_use_rm, w_hazard, w_load;

  logic              r_valid;
  logic [PC_W-1:0]   r_pc;
  logic [10:0]       r_opcode;
  logic [4:0]        r_rn, r_rm, r_rd;
  logic [DATA_W-1:0] r_imm;
  logic              r_uncond, r_branch, r_br_nz, r_memread, r_memwrite;
  logic              r_memtoreg, r_alusrc, r_regwrite, r_illegal;
  logic [1:0]        r_aluop;
  logic [CNT_W-1:0]  r_stall_cnt;

  assign w_op11 = in_inst[31:21];
  assign w_op10 = in_inst[31:22];
  assign w_is_r = (w_op11 == 11'h458) || (w_op11 == 11'h658) ||
                  (w_op11 == 11'h450) || (w_op11 == 11'h550);
  assign w_is_i = (w_op10 == 10'h244) || (w_op10 == 10'h344) ||
                  (w_op10 == 10'h248) || (w_op10 == 10'h2C8);

  // Register fields not used by a format are forced to 0; w_use_* mark real reads.
  always_comb begin
    w_rn = '0; w_rm = '0; w_rd = '0; w_imm = '0; w_aluop = 2'b00;
    w_uncond = 1'b0; w_branch = 1'b0; w_br_nz = 1'b0; w_memread = 1'b0;
    w_memwrite = 1'b0; w_memtoreg = 1'b0; w_alusrc = 1'b0; w_regwrite = 1'b0;
    w_illegal = 1'b0; w_use_rn = 1'b0; w_use_rm = 1'b0;
    if (in_inst == 32'h0000_0000 || in_inst == 32'hD503_201F) begin
      w_illegal = 1'b0;
    end else if (in_inst[30:26] == 5'b00101) begin
      w_uncond = 1'b1;
      w_imm    = {{(DATA_W-26){in_inst[25]}}, in_inst[25:0]};
      if (in_inst[31]) begin
        w_regwrite = 1'b1;
        w_rd       = 5'd30;
      end
    end else if (in_inst[31:25] == 7'b1011010) begin
      w_branch = 1'b1; w_br_nz = in_inst[24]; w_aluop = 2'b01;
      w_rm = in_inst[4:0]; w_use_rm = 1'b1;
      w_imm = {{(DATA_W-19){in_inst[23]}}, in_inst[23:5]};
    end else if (w_op11 == 11'b11111000010) begin
      w_memread = 1'b1; w_memtoreg = 1'b1; w_regwrite = 1'b1; w_alusrc = 1'b1;
      w_rn = in_inst[9:5]; w_rd = in_inst[4:0]; w_use_rn = 1'b1;
      w_imm = {{(DATA_W-9){in_inst[20]}}, in_inst[20:12]};
    end else if (w_op11 == 11'b11111000000) begin
      w_memwrite = 1'b1; w_alusrc = 1'b1;
      w_rn = in_inst[9:5]; w_rm = in_inst[4:0]; w_use_rn = 1'b1; w_use_rm = 1'b1;
      w_imm = {{(DATA_W-9){in_inst[20]}}, in_inst[20:12]};
    end else if (w_is_r) begin
      w_regwrite = 1'b1; w_aluop = 2'b10;
      w_rn = in_inst[9:5]; w_rm = in_inst[20:16]; w_rd = in_inst[4:0];
      w_use_rn = 1'b1; w_use_rm = 1'b1;
    end else if (w_is_i) begin
      w_regwrite = 1'b1; w_alusrc = 1'b1; w_aluop = 2'b10;
      w_rn = in_inst[9:5]; w_rd = in_inst[4:0]; w_use_rn = 1'b1;
      w_imm = {{(DATA_W-12){1'b0}}, in_inst[21:10]};
    end else if (in_inst[31:23] == 9'b111100101) begin
      // MOVK keeps the untouched halfwords of Rd, so Rd is also a source.
      w_regwrite = 1'b1; w_alusrc = 1'b1; w_aluop = 2'b11;
      w_rn = in_inst[4:0]; w_rd = in_inst[4:0]; w_use_rn = 1'b1;
      w_imm = {{(DATA_W-16){1'b0}}, in_inst[20:5]} << {in_inst[22:21], 4'b0000};
    end else begin
      w_illegal = 1'b1;
    end
  end

`ifdef LOAD_USE_INTERLOCK_EN
  assign w_hazard = r_valid && r_memread && (r_rd != 5'd31) &&
                    ((w_use_rn && (w_rn == r_rd)) || (w_use_rm && (w_rm == r_rd)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (in_valid && w_hazard && (!r_valid || out_ready) && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end
`else
  assign w_hazard    = 1'b0;
  assign r_stall_cnt = '0;
`endif

  assign in_ready = (!r_valid || out_ready) && !w_hazard;
  assign w_load   = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0; r_pc <= '0; r_opcode <= '0; r_rn <= '0; r_rm <= '0; r_rd <= '0;
      r_imm <= '0; r_uncond <= 1'b0; r_branch <= 1'b0; r_br_nz <= 1'b0;
      r_memread <= 1'b0; r_memwrite <= 1'b0; r_memtoreg <= 1'b0; r_alusrc <= 1'b0;
      r_regwrite <= 1'b0; r_aluop <= 2'b00; r_illegal <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1; r_pc <= in_pc; r_opcode <= w_op11;
      r_rn <= w_rn; r_rm <= w_rm; r_rd <= w_rd; r_imm <= w_imm;
      r_uncond <= w_uncond; r_branch <= w_branch; r_br_nz <= w_br_nz;
      r_memread <= w_memread; r_memwrite <= w_memwrite; r_memtoreg <= w_memtoreg;
      r_alusrc <= w_alusrc; r_regwrite <= w_regwrite; r_aluop <= w_aluop;
      r_illegal <= w_illegal;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid    = r_valid;
  assign out_pc       = r_pc;
  assign out_opcode   = r_opcode;
  assign out_rn       = r_rn;
  assign out_rm       = r_rm;
  assign out_rd       = r_rd;
  assign out_imm      = r_imm;
  assign out_uncond   = r_uncond;
  assign out_branch   = r_branch;
  assign out_br_nz    = r_br_nz;
  assign out_memread  = r_memread;
  assign out_memwrite = r_memwrite;
  assign out_memtoreg = r_memtoreg;
  assign out_alusrc   = r_alusrc;
  assign out_regwrite = r_regwrite;
  assign out_aluop    = r_aluop;
  assign out_illegal  = r_illegal;
  assign stall_cnt    = r_stall_cnt;
endmodule

// File: tb/tb_decode_stage_m.sv
// tb/tb_decode_stage_m.sv - directed vector bench for decode_stage_m
// Expectations follow LOAD_USE_INTERLOCK_EN the same way the design does.
module tb_decode_stage_m;
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc, out_pc, out_imm;
  logic [10:0] out_opcode;
  logic [4:0]  out_rn, out_rm, out_rd;
  logic        out_uncond, out_branch, out_br_nz, out_memread, out_memwrite;
  logic        out_memtoreg, out_alusrc, out_regwrite, out_illegal;
  logic [1:0]  out_aluop;
  logic [15:0] stall_cnt;

`ifdef LOAD_USE_INTERLOCK_EN
  localparam bit IL = 1'b1;
`else
  localparam bit IL = 1'b0;
`endif

  decode_stage_m #(.DATA_W(64), .PC_W(64), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_opcode(out_opcode), .out_rn(out_rn), .out_rm(out_rm),
    .out_rd(out_rd), .out_imm(out_imm), .out_uncond(out_uncond), .out_branch(out_branch),
    .out_br_nz(out_br_nz), .out_memread(out_memread), .out_memwrite(out_memwrite),
    .out_memtoreg(out_memtoreg), .out_alusrc(out_alusrc), .out_regwrite(out_regwrite),
    .out_aluop(out_aluop), .out_illegal(out_illegal), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  rn, rm, rd;
    logic [63:0] imm;
    logic [10:0] ctrl;  // uncond,branch,br_nz,memread,memwrite,memtoreg,alusrc,regwrite,aluop[1:0],illegal
  } vec_t;

  vec_t vecs[14];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] ctrl_now();
    return {out_uncond, out_branch, out_br_nz, out_memread, out_memwrite, out_memtoreg,
            out_alusrc, out_regwrite, out_aluop, out_illegal};
  endfunction

  initial begin
    vecs[0]  = '{32'h91001441, 5'd2,  5'd0,  5'd1,  64'd5,                  11'b00000011100};
    vecs[1]  = '{32'hF85F8083, 5'd4,  5'd0,  5'd3,  64'hFFFF_FFFF_FFFF_FFF8, 11'b00010111000};
    vecs[2]  = '{32'h8B060065, 5'd3,  5'd6,  5'd5,  64'd0,                  11'b00000001100};
    vecs[3]  = '{32'hF8010041, 5'd2,  5'd1,  5'd0,  64'd16,                 11'b00001010000};
    vecs[4]  = '{32'hB5FFFFC7, 5'd0,  5'd7,  5'd0,  64'hFFFF_FFFF_FFFF_FFFE, 11'b01100000010};
    vecs[5]  = '{32'h94000004, 5'd0,  5'd0,  5'd30, 64'd4,                  11'b10000001000};
    vecs[6]  = '{32'h17FFFFFF, 5'd0,  5'd0,  5'd0,  64'hFFFF_FFFF_FFFF_FFFF, 11'b10000000000};
    vecs[7]  = '{32'hF2B7DDE9, 5'd9,  5'd0,  5'd9,  64'h0000_0000_BEEF_0000, 11'b00000011110};
    vecs[8]  = '{32'hF2E00020, 5'd0,  5'd0,  5'd0,  64'h0001_0000_0000_0000, 11'b00000011110};
    vecs[9]  = '{32'hD503201F, 5'd0,  5'd0,  5'd0,  64'd0,                  11'b00000000000};
    vecs[10] = '{32'h00000000, 5'd0,  5'd0,  5'd0,  64'd0,                  11'b00000000000};
    vecs[11] = '{32'hFFFFFFFF, 5'd0,  5'd0,  5'd0,  64'd0,                  11'b00000000001};
    vecs[12] = '{32'hAA0C016A, 5'd11, 5'd12, 5'd10, 64'd0,                  11'b00000001100};
    vecs[13] = '{32'h923FFC21, 5'd1,  5'd0,  5'd1,  64'hFFF,                11'b00000011100};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_inst = 32'h0; in_pc = 64'h0;
    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_stall_cnt", {48'd0, stall_cnt}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_ctrl", {53'd0, ctrl_now()}, 64'd0);
    step();
    reset = 1'b0;
    step();

    for (int i = 0; i < 14; i++) begin
      in_inst  = vecs[i].inst;
      in_pc    = 64'h400 + 64'(i * 4);
      in_valid = 1'b1;
      for (int n = 0; n < 8 && !in_ready; n++) step();
      chk($sformatf("v%0d_ready", i), {63'd0, in_ready}, 64'd1);
      step();
      in_valid = 1'b0;
      chk($sformatf("v%0d_valid", i), {63'd0, out_valid}, 64'd1);
      chk($sformatf("v%0d_pc", i), out_pc, 64'h400 + 64'(i * 4));
      chk($sformatf("v%0d_opcode", i), {53'd0, out_opcode}, {53'd0, vecs[i].inst[31:21]});
      chk($sformatf("v%0d_rn", i), {59'd0, out_rn}, {59'd0, vecs[i].rn});
      chk($sformatf("v%0d_rm", i), {59'd0, out_rm}, {59'd0, vecs[i].rm});
      chk($sformatf("v%0d_rd", i), {59'd0, out_rd}, {59'd0, vecs[i].rd});
      chk($sformatf("v%0d_imm", i), out_imm, vecs[i].imm);
      chk($sformatf("v%0d_ctrl", i), {53'd0, ctrl_now()}, {53'd0, vecs[i].ctrl});
      step();
    end

    // LDUR X3 followed by a dependent ADD reading X3.
    in_inst = 32'hF85F8083; in_valid = 1'b1;
    step();
    chk("lu_ld_valid", {63'd0, out_valid}, 64'd1);
    chk("lu_ld_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
    in_inst = 32'h8B060065;
    #1;
    chk("lu_add_ready", {63'd0, in_ready}, IL ? 64'd0 : 64'd1);
    step();
`ifdef LOAD_USE_INTERLOCK_EN
    chk("lu_bubble", {63'd0, out_valid}, 64'd0);
    chk("lu_cnt_bubble", {48'd0, stall_cnt}, 64'd1);
    step();
`endif
    chk("lu_add_valid", {63'd0, out_valid}, 64'd1);
    chk("lu_add_rd", {59'd0, out_rd}, 64'd5);
    chk("lu_add_rm", {59'd0, out_rm}, 64'd6);
    in_valid = 1'b0;
    step();
    chk("lu_cnt_final", {48'd0, stall_cnt}, IL ? 64'd1 : 64'd0);

    // Load into X31 never interlocks a reader of X31.
    in_inst = 32'hF85F809F; in_valid = 1'b1;
    step();
    in_inst = 32'h8B0603E5;
    #1;
    chk("x31_ready", {63'd0, in_ready}, 64'd1);
    step();
    chk("x31_rn", {59'd0, out_rn}, 64'd31);
    in_valid = 1'b0;
    step();

    // Downstream back-pressure holds the bundle.
    in_inst = 32'h91001441; in_valid = 1'b1;
    step();
    out_ready = 1'b0;
    in_inst = 32'hAA0C016A;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d_valid", c), {63'd0, out_valid}, 64'd1);
      chk($sformatf("bp%0d_rd", c), {59'd0, out_rd}, 64'd1);
      chk($sformatf("bp%0d_imm", c), out_imm, 64'd5);
      chk($sformatf("bp%0d_ready", c), {63'd0, in_ready}, 64'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_next_rd", {59'd0, out_rd}, 64'd10);
    in_valid = 1'b0;
    step();

    // Flush on the same edge as a handshake discards the instruction.
    in_inst = 32'h91001441; in_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    step();
    chk("flush_stays", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset with a bundle in flight.
    in_inst = 32'h91001441; in_valid = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("mid_pre_valid", {63'd0, out_valid}, 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_cnt", {48'd0, stall_cnt}, 64'd0);
    chk("mid_rst_ready", {63'd0, in_ready}, 64'd1);
    chk("mid_rst_rd", {59'd0, out_rd}, 64'd0);
    step();
    reset = 1'b0; out_ready = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
